ecc_operand_loader: RTL and testbench
=====================================

ECC_OPERAND_LOADER -- requirements
Module: ecc_operand_loader

Interface
REQ-001 SHALL have parameter pWORDS, default 8, 32-bit words per operand (256 bits).
REQ-002 SHALL have parameter pSEL_RESERVED, default 3, the I_wr_sel code that is always rejected.
REQ-003 SHALL have port crypto_clk  in  1  the only clock; all logic on its rising edge.
REQ-004 SHALL have port reset_i  in  1  synchronous, active-high reset.
REQ-005 SHALL have port I_wr_valid  in  1  one-cycle byte write strobe from the register block.
REQ-006 SHALL have port I_wr_sel  in  2  target operand: 0=k, 1=gx, 2=gy.
REQ-007 SHALL have port I_wr_bytecnt  in  5  byte index; 0 = least-significant byte of the operand.
REQ-008 SHALL have port I_wr_byte  in  8  byte data.
REQ-009 SHALL have port I_clear  in  1  clears all loaded masks.
REQ-010 SHALL have port I_lock  in  1  high while the point multiplier is busy.
REQ-011 SHALL have port I_bram_rd_msb  in  1  reverses the word order seen by the core.
REQ-012 SHALL have ports k_addr, gx_addr, gy_addr  in  3 each  word addresses from the multiplier core.
REQ-013 SHALL have ports O_k_word, O_gx_word, O_gy_word  out  32 each  registered read data.
REQ-014 SHALL have port O_loaded  out  3  per-operand flag {gy,gx,k}: all 32 bytes written since the last clear.
REQ-015 SHALL have port O_ready  out  1  high in state FULL.
REQ-016 SHALL have port O_wr_drop  out  1  one-cycle pulse when a write is rejected.

Function
REQ-017 SHALL store each accepted byte in word I_wr_bytecnt[4:2], lane I_wr_bytecnt[1:0] (lane 0 = bits 7:0), visible to reads from the next cycle.
REQ-018 SHALL set byte-mask bit I_wr_bytecnt of the selected operand on each accepted write; O_loaded[i] SHALL be the AND of operand i's 32 mask bits, registered.
REQ-019 SHALL reject a write when I_lock=1, when I_wr_sel=pSEL_RESERVED, or when I_clear=1 in the same cycle. A rejected write SHALL change neither storage nor masks and SHALL pulse O_wr_drop for exactly one cycle, in the cycle after the strobe.
REQ-020 SHALL register each word read with one-cycle latency: the address sampled at edge N drives data after edge N+1; each of the three read ports is independent.
REQ-021 SHALL read physical word addr when I_bram_rd_msb=0 and physical word 7-addr when it is 1.
REQ-022 SHALL implement the FSM EMPTY, PARTIAL, FULL, LOCKED:
- EMPTY->PARTIAL on the first accepted write.
- PARTIAL->FULL when all three O_loaded bits are 1.
- FULL->LOCKED when I_lock=1.
- LOCKED->FULL when I_lock=0.
- Any state->EMPTY on I_clear, unless the state is LOCKED, where I_clear is ignored.
REQ-023 SHALL keep storage contents on I_clear; only the masks and the FSM state are cleared.
REQ-024 SHALL accept a rewrite of an already-written byte, overwriting the data with the mask unchanged.
REQ-025 SHALL let I_lock high in EMPTY or PARTIAL block writes without changing state.

Reset
REQ-026 SHALL, on reset_i, zero all storage words, all masks, O_loaded, O_wr_drop and the three word outputs, set O_ready=0, and enter EMPTY.
REQ-027 SHALL give reset_i priority over every other input, including mid-load and while in LOCKED.

Configuration
REQ-028 With ECC_LOADER_READBACK_EN defined, SHALL add inputs I_rd_sel (2) and I_rd_bytecnt (5) and output O_rd_byte (8) returning the stored byte with one-cycle registered latency; a reserved select SHALL read 0.
REQ-029 Without ECC_LOADER_READBACK_EN, those ports and their logic SHALL be absent.

Structure
REQ-030 SHALL take the select codes (SEL_K, SEL_GX, SEL_GY), the FSM state encoding, and the word count from the shared ECC package.
REQ-031 SHALL instantiate one sub-module, ecc_operand_bank (32-byte store, mask, registered word read port), three times.

Verification
REQ-032 Write k bytes 0..31 = 0x00..0x1F, then read k_addr=0 -> O_k_word=0x03020100 one cycle later; O_loaded=3'b001.
REQ-033 Load all three operands -> O_ready rises the cycle after the final O_loaded bit sets; assert I_lock -> LOCKED; a write to gx byte 5 -> O_wr_drop pulses and the data is unchanged.
REQ-034 Set I_bram_rd_msb=1 with k_addr=0 -> O_k_word=0x1F1E1D1C.
REQ-035 Assert I_clear together with a write in PARTIAL -> state EMPTY, write dropped, O_wr_drop=1, storage retained.
REQ-036 Write with I_wr_sel=3 -> O_wr_drop=1 with no mask change; assert reset_i in LOCKED -> EMPTY with all outputs 0 the next cycle.

Source files
------------

// File: rtl/ecc_operand_loader_pkg.sv
// Shared ECC definitions: operand select codes, operand word count and loader FSM encoding.
package ecc_operand_loader_pkg;

  localparam int unsigned WORDS = 8;

  localparam logic [1:0] SEL_K  = 2'd0;
  localparam logic [1:0] SEL_GX = 2'd1;
  localparam logic [1:0] SEL_GY = 2'd2;

  typedef enum logic [1:0] {
    StEmpty,
    StPartial,
    StFull,
    StLocked
  } state_e;

endpackage

// File: rtl/ecc_operand_loader_if.sv
// Byte-write bus from the register block into the operand loader.
interface ecc_operand_loader_if;

  logic       I_wr_valid;
  logic [1:0] I_wr_sel;
  logic [4:0] I_wr_bytecnt;
  logic [7:0] I_wr_byte;

  modport master (output I_wr_valid, output I_wr_sel, output I_wr_bytecnt, output I_wr_byte);
  modport slave  (input I_wr_valid, input I_wr_sel, input I_wr_bytecnt, input I_wr_byte);

endinterface

// File: rtl/ecc_operand_bank.sv
// One operand: byte-addressed word store, per-byte loaded mask, registered word read port.
// Optional combinational byte readback under ECC_LOADER_READBACK_EN.
module ecc_operand_bank import ecc_operand_loader_pkg::*; #(
  parameter int unsigned pWORDS = WORDS,
  localparam int unsigned AW = $clog2(pWORDS),
  localparam int unsigned NB = pWORDS * 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          clr,
  input  logic [AW+1:0] bytecnt,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] rd_addr,
  input  logic          rd_msb,
  output logic [31:0]   rd_word,
  output logic          loaded
`ifdef ECC_LOADER_READBACK_EN
  ,
  input  logic [AW+1:0] rb_bytecnt,
  output logic [7:0]    rb_byte
`endif
);

  logic [31:0]   mem_q [pWORDS];
  logic [NB-1:0] mask_q, mask_d;
  logic [AW-1:0] phys;

  // Mask next state: clear wins; a rewrite leaves the bit already set.
  always_comb begin
    mask_d = mask_q;
    if (clr) begin
      mask_d = '0;
    end else if (we) begin
      mask_d[bytecnt] = 1'b1;
    end
  end

  // Word order reversal for MSB-first consumers.
  always_comb begin
    phys = rd_msb ? (AW'(pWORDS - 1) - rd_addr) : rd_addr;
  end

  // Storage, mask, loaded flag and read register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(pWORDS); i++) begin
        mem_q[i] <= '0;
      end
      mask_q  <= '0;
      loaded  <= 1'b0;
      rd_word <= '0;
    end else begin
      if (we) begin
        mem_q[bytecnt[AW+1:2]][{bytecnt[1:0], 3'b000} +: 8] <= wdata;
      end
      mask_q  <= mask_d;
      loaded  <= &mask_d;
      rd_word <= mem_q[phys];
    end
  end

`ifdef ECC_LOADER_READBACK_EN
  // Raw byte view for the readback port; registered in the top.
  always_comb begin
    rb_byte = mem_q[rb_bytecnt[AW+1:2]][{rb_bytecnt[1:0], 3'b000} +: 8];
  end
`endif

endmodule

// File: rtl/ecc_operand_loader.sv
// Loads the k, gx and gy operands for the point multiplier byte by byte and serves them as
// 32-bit words. Optional byte readback port enabled by defining ECC_LOADER_READBACK_EN.
module ecc_operand_loader import ecc_operand_loader_pkg::*; #(
  parameter int unsigned pWORDS = WORDS,
  parameter int unsigned pSEL_RESERVED = 3,
  localparam int unsigned AW = $clog2(pWORDS)
) (
  input  logic                 crypto_clk,
  input  logic                 reset_i,
  ecc_operand_loader_if.slave  wr,
  input  logic                 I_clear,
  input  logic                 I_lock,
  input  logic                 I_bram_rd_msb,
  input  logic [AW-1:0]        k_addr,
  input  logic [AW-1:0]        gx_addr,
  input  logic [AW-1:0]        gy_addr,
  output logic [31:0]          O_k_word,
  output logic [31:0]          O_gx_word,
  output logic [31:0]          O_gy_word,
  output logic [2:0]           O_loaded,
  output logic                 O_ready,
  output logic                 O_wr_drop
`ifdef ECC_LOADER_READBACK_EN
  ,
  input  logic [1:0]           I_rd_sel,
  input  logic [AW+1:0]        I_rd_bytecnt,
  output logic [7:0]           O_rd_byte
`endif
);

  state_e state_q, state_d;
  logic   accept, clr_masks, drop_q;
  logic   we_k, we_gx, we_gy;
`ifdef ECC_LOADER_READBACK_EN
  logic [7:0] rb_k, rb_gx, rb_gy;
`endif

  // Write acceptance and per-bank strobes; a clear in LOCKED leaves the masks alone.
  always_comb begin
    accept    = wr.I_wr_valid & ~I_lock & ~I_clear & (wr.I_wr_sel != 2'(pSEL_RESERVED));
    we_k      = accept & (wr.I_wr_sel == SEL_K);
    we_gx     = accept & (wr.I_wr_sel == SEL_GX);
    we_gy     = accept & (wr.I_wr_sel == SEL_GY);
    clr_masks = I_clear & (state_q != StLocked);
  end

  ecc_operand_bank #(.pWORDS(pWORDS)) u_bank_k (
    .clk        (crypto_clk),
    .rst        (reset_i),
    .we         (we_k),
    .clr        (clr_masks),
    .bytecnt    (wr.I_wr_bytecnt[AW+1:0]),
    .wdata      (wr.I_wr_byte),
    .rd_addr    (k_addr),
    .rd_msb     (I_bram_rd_msb),
    .rd_word    (O_k_word),
    .loaded     (O_loaded[0])
`ifdef ECC_LOADER_READBACK_EN
    ,
    .rb_bytecnt (I_rd_bytecnt),
    .rb_byte    (rb_k)
`endif
  );

  ecc_operand_bank #(.pWORDS(pWORDS)) u_bank_gx (
    .clk        (crypto_clk),
    .rst        (reset_i),
    .we         (we_gx),
    .clr        (clr_masks),
    .bytecnt    (wr.I_wr_bytecnt[AW+1:0]),
    .wdata      (wr.I_wr_byte),
    .rd_addr    (gx_addr),
    .rd_msb     (I_bram_rd_msb),
    .rd_word    (O_gx_word),
    .loaded     (O_loaded[1])
`ifdef ECC_LOADER_READBACK_EN
    ,
    .rb_bytecnt (I_rd_bytecnt),
    .rb_byte    (rb_gx)
`endif
  );

  ecc_operand_bank #(.pWORDS(pWORDS)) u_bank_gy (
    .clk        (crypto_clk),
    .rst        (reset_i),
    .we         (we_gy),
    .clr        (clr_masks),
    .bytecnt    (wr.I_wr_bytecnt[AW+1:0]),
    .wdata      (wr.I_wr_byte),
    .rd_addr    (gy_addr),
    .rd_msb     (I_bram_rd_msb),
    .rd_word    (O_gy_word),
    .loaded     (O_loaded[2])
`ifdef ECC_LOADER_READBACK_EN
    ,
    .rb_bytecnt (I_rd_bytecnt),
    .rb_byte    (rb_gy)
`endif
  );

  // Loader FSM next state; LOCKED ignores clear until the multiplier releases the lock.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) state_d = StPartial;
      end
      StPartial: begin
        if (I_clear)        state_d = StEmpty;
        else if (&O_loaded) state_d = StFull;
      end
      StFull: begin
        if (I_clear)     state_d = StEmpty;
        else if (I_lock) state_d = StLocked;
      end
      StLocked: begin
        if (!I_lock) state_d = StFull;
      end
      default: state_d = StEmpty;
    endcase
  end

  // State register and drop pulse.
  always_ff @(posedge crypto_clk) begin
    if (reset_i) begin
      state_q <= StEmpty;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= wr.I_wr_valid & ~accept;
    end
  end

  assign O_ready   = (state_q == StFull);
  assign O_wr_drop = drop_q;

`ifdef ECC_LOADER_READBACK_EN
  // Registered byte readback; the reserved select reads zero.
  always_ff @(posedge crypto_clk) begin
    if (reset_i) begin
      O_rd_byte <= '0;
    end else begin
      case (I_rd_sel)
        SEL_K:   O_rd_byte <= rb_k;
        SEL_GX:  O_rd_byte <= rb_gx;
        SEL_GY:  O_rd_byte <= rb_gy;
        default: O_rd_byte <= '0;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_ecc_operand_loader.sv
// Directed self-checking bench for ecc_operand_loader.
module tb_ecc_operand_loader;

  logic       crypto_clk;
  logic       reset_i;
  logic       I_clear, I_lock, I_bram_rd_msb;
  logic [2:0] k_addr, gx_addr, gy_addr;
  logic [31:0] O_k_word, O_gx_word, O_gy_word;
  logic [2:0] O_loaded;
  logic       O_ready, O_wr_drop;
`ifdef ECC_LOADER_READBACK_EN
  logic [1:0] I_rd_sel;
  logic [4:0] I_rd_bytecnt;
  logic [7:0] O_rd_byte;
`endif

  int checks;
  int failures;

  ecc_operand_loader_if wr_if ();

  ecc_operand_loader dut (
    .crypto_clk    (crypto_clk),
    .reset_i       (reset_i),
    .wr            (wr_if),
    .I_clear       (I_clear),
    .I_lock        (I_lock),
    .I_bram_rd_msb (I_bram_rd_msb),
    .k_addr        (k_addr),
    .gx_addr       (gx_addr),
    .gy_addr       (gy_addr),
    .O_k_word      (O_k_word),
    .O_gx_word     (O_gx_word),
    .O_gy_word     (O_gy_word),
    .O_loaded      (O_loaded),
    .O_ready       (O_ready),
    .O_wr_drop     (O_wr_drop)
`ifdef ECC_LOADER_READBACK_EN
    ,
    .I_rd_sel      (I_rd_sel),
    .I_rd_bytecnt  (I_rd_bytecnt),
    .O_rd_byte     (O_rd_byte)
`endif
  );

  initial crypto_clk = 1'b0;
  always #5 crypto_clk = ~crypto_clk;

  task automatic step();
    @(posedge crypto_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr_byte(input logic [1:0] sel, input logic [4:0] idx, input logic [7:0] data);
    wr_if.I_wr_valid   = 1'b1;
    wr_if.I_wr_sel     = sel;
    wr_if.I_wr_bytecnt = idx;
    wr_if.I_wr_byte    = data;
    step();
    wr_if.I_wr_valid   = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset_i = 1'b1;
    I_clear = 1'b0;
    I_lock = 1'b0;
    I_bram_rd_msb = 1'b0;
    k_addr = '0;
    gx_addr = '0;
    gy_addr = '0;
    wr_if.I_wr_valid = 1'b0;
    wr_if.I_wr_sel = '0;
    wr_if.I_wr_bytecnt = '0;
    wr_if.I_wr_byte = '0;
`ifdef ECC_LOADER_READBACK_EN
    I_rd_sel = '0;
    I_rd_bytecnt = '0;
`endif
    step();
    step();
    reset_i = 1'b0;

    // Reset state
    check("rst_loaded", 32'(O_loaded), 32'h0);
    check("rst_ready", 32'(O_ready), 32'h0);
    check("rst_drop", 32'(O_wr_drop), 32'h0);
    check("rst_kword", O_k_word, 32'h0);

    // Lock in EMPTY blocks a write
    I_lock = 1'b1;
    wr_byte(2'd0, 5'd0, 8'h77);
    check("lock_empty_drop", 32'(O_wr_drop), 32'h1);
    check("lock_empty_loaded", 32'(O_loaded), 32'h0);
    I_lock = 1'b0;
    step();
    check("drop_one_cycle", 32'(O_wr_drop), 32'h0);
    check("lock_empty_data", O_k_word, 32'h0);

    // Load k with 0x00..0x1F
    for (int i = 0; i < 32; i++) wr_byte(2'd0, 5'(i), 8'(i));
    check("k_loaded", 32'(O_loaded), 32'h1);
    check("k_partial_ready", 32'(O_ready), 32'h0);
    k_addr = 3'd0;
    step();
    check("k_word0", O_k_word, 32'h0302_0100);
    k_addr = 3'd7;
    step();
    check("k_word7", O_k_word, 32'h1F1E_1D1C);
    I_bram_rd_msb = 1'b1;
    k_addr = 3'd0;
    step();
    check("k_msb_word0", O_k_word, 32'h1F1E_1D1C);
    k_addr = 3'd7;
    step();
    check("k_msb_word7", O_k_word, 32'h0302_0100);
    I_bram_rd_msb = 1'b0;
    k_addr = 3'd0;

    // Reserved select is dropped
    wr_byte(2'd3, 5'd0, 8'hFF);
    check("rsv_drop", 32'(O_wr_drop), 32'h1);
    check("rsv_loaded", 32'(O_loaded), 32'h1);

    // Clear with a write in PARTIAL
    I_clear = 1'b1;
    wr_byte(2'd1, 5'd0, 8'hAA);
    I_clear = 1'b0;
    check("clr_drop", 32'(O_wr_drop), 32'h1);
    check("clr_loaded", 32'(O_loaded), 32'h0);
    step();
    check("clr_retained", O_k_word, 32'h0302_0100);

    // Load all three operands
    for (int i = 0; i < 32; i++) wr_byte(2'd0, 5'(i), 8'(i));
    for (int i = 0; i < 32; i++) wr_byte(2'd1, 5'(i), 8'(8'h40 + i));
    for (int i = 0; i < 32; i++) wr_byte(2'd2, 5'(i), 8'(8'h80 + i));
    check("all_loaded", 32'(O_loaded), 32'h7);
    check("ready_lags_loaded", 32'(O_ready), 32'h0);
    gx_addr = 3'd1;
    gy_addr = 3'd7;
    step();
    check("full_ready", 32'(O_ready), 32'h1);
    check("gx_word1", O_gx_word, 32'h4746_4544);
    check("gy_word7", O_gy_word, 32'h9F9E_9D9C);
`ifdef ECC_LOADER_READBACK_EN
    I_rd_sel = 2'd1;
    I_rd_bytecnt = 5'd5;
    step();
    check("rb_gx5", 32'(O_rd_byte), 32'h45);
    I_rd_sel = 2'd3;
    step();
    check("rb_reserved", 32'(O_rd_byte), 32'h0);
`endif

    // Rewrite in FULL keeps the mask and updates the data
    wr_byte(2'd0, 5'd0, 8'h55);
    check("rewrite_drop", 32'(O_wr_drop), 32'h0);
    check("rewrite_loaded", 32'(O_loaded), 32'h7);
    step();
    check("rewrite_word", O_k_word, 32'h0302_0155);
    check("rewrite_ready", 32'(O_ready), 32'h1);

    // Lock: LOCKED drops writes and ignores clear
    I_lock = 1'b1;
    step();
    check("locked_ready", 32'(O_ready), 32'h0);
    wr_byte(2'd1, 5'd5, 8'hEE);
    check("locked_drop", 32'(O_wr_drop), 32'h1);
    step();
    check("locked_gx_word", O_gx_word, 32'h4746_4544);
    I_clear = 1'b1;
    step();
    I_clear = 1'b0;
    check("locked_clear_ignored", 32'(O_loaded), 32'h7);
    I_lock = 1'b0;
    step();
    check("unlock_ready", 32'(O_ready), 32'h1);

    // Reset while LOCKED
    I_lock = 1'b1;
    step();
    check("relock_ready", 32'(O_ready), 32'h0);
    reset_i = 1'b1;
    step();
    check("rst_lock_loaded", 32'(O_loaded), 32'h0);
    check("rst_lock_ready", 32'(O_ready), 32'h0);
    check("rst_lock_drop", 32'(O_wr_drop), 32'h0);
    check("rst_lock_k", O_k_word, 32'h0);
    check("rst_lock_gx", O_gx_word, 32'h0);
    check("rst_lock_gy", O_gy_word, 32'h0);
    reset_i = 1'b0;
    I_lock = 1'b0;
    k_addr = 3'd7;
    step();
    check("rst_storage_zero", O_k_word, 32'h0);
    check("rst_empty_ready", 32'(O_ready), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
